// File: rtl/slice_issue_seq.sv
// Replays one accepted op across the slices, one slice index per beat, honouring
// downstream stall, with a registered last-beat marker and back-to-back reload.
module slice_issue_seq #(
    parameter int NUM_SLICES = 8,
    parameter int IDX_W      = $clog2(NUM_SLICES),
    parameter int OP_W       = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             I_Valid,
    output logic             O_Ready,
    input  logic [OP_W-1:0]  I_Op,
    input  logic [IDX_W:0]   I_Len,
    input  logic             I_Flush,
    input  logic             I_Stall,
    output logic             O_Valid,
    output logic [OP_W-1:0]  O_Op,
    output logic [IDX_W-1:0] O_Slice_Idx,
    output logic             O_Last,
    output logic             O_Busy
);
    // state | meaning
    // IDLE  | no op in flight, ready for a new op
    // ISSUE | replaying latched op, one slice per unstalled cycle
    typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

    localparam logic [IDX_W:0]   NS      = (IDX_W + 1)'(NUM_SLICES);
    localparam logic [IDX_W:0]   LEN_ONE = (IDX_W + 1)'(1);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

    state_t            state_q, state_d;
    logic [IDX_W:0]    len_q, len_d;
    logic [IDX_W-1:0]  idx_q, idx_d, idx_inc;
    logic [OP_W-1:0]   op_q, op_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic [IDX_W:0]    eff_len;
    logic              accept;

    assign eff_len = (I_Len == '0 || I_Len > NS) ? NS : I_Len;
    assign idx_inc = idx_q + IDX_ONE;

    assign O_Ready = !I_Flush && (state_q == IDLE || (last_q && !I_Stall));
    assign accept  = I_Valid && O_Ready;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        op_d    = op_q;
        valid_d = valid_q;
        last_d  = last_q;
        if (I_Flush) begin
            state_d = IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            idx_d   = '0;
        end else if (accept) begin
            // covers both a fresh start from IDLE and a no-bubble reload on the last beat
            state_d = ISSUE;
            len_d   = eff_len;
            op_d    = I_Op;
            idx_d   = '0;
            valid_d = 1'b1;
            last_d  = (eff_len == LEN_ONE);
        end else if (state_q == ISSUE && !I_Stall) begin
            if (last_q) begin
                state_d = IDLE;
                valid_d = 1'b0;
                last_d  = 1'b0;
                idx_d   = '0;
            end else begin
                idx_d  = idx_inc;
                last_d = ({1'b0, idx_inc} == len_q - LEN_ONE);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            op_q    <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            op_q    <= op_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign O_Valid     = valid_q;
    assign O_Op        = op_q;
    assign O_Slice_Idx = idx_q;
    assign O_Last      = last_q;
    assign O_Busy      = (state_q == ISSUE);
endmodule

// File: tb/tb_slice_issue_seq.sv
// Scoreboard bench for slice_issue_seq: expected beats are queued when an op is
// accepted and compared beat by beat, including stall holds, flush and reset.
module tb_slice_issue_seq;
    localparam int NUM_SLICES = 8;
    localparam int IDX_W      = 3;
    localparam int OP_W       = 16;

    logic             clock = 1'b0;
    logic             reset;
    logic             I_Valid;
    logic             O_Ready;
    logic [OP_W-1:0]  I_Op;
    logic [IDX_W:0]   I_Len;
    logic             I_Flush;
    logic             I_Stall;
    logic             O_Valid;
    logic [OP_W-1:0]  O_Op;
    logic [IDX_W-1:0] O_Slice_Idx;
    logic             O_Last;
    logic             O_Busy;

    slice_issue_seq #(.NUM_SLICES(NUM_SLICES), .IDX_W(IDX_W), .OP_W(OP_W)) dut (
        .clock(clock), .reset(reset), .I_Valid(I_Valid), .O_Ready(O_Ready),
        .I_Op(I_Op), .I_Len(I_Len), .I_Flush(I_Flush), .I_Stall(I_Stall),
        .O_Valid(O_Valid), .O_Op(O_Op), .O_Slice_Idx(O_Slice_Idx),
        .O_Last(O_Last), .O_Busy(O_Busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [OP_W-1:0] op;
        int              idx;
        logic            last;
    } beat_t;

    beat_t sb[$];
    int    n_chk  = 0;
    int    n_pass = 0;
    int    n_beats = 0;
    logic  after_clear = 1'b0;
    logic  after_reset = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    // Inputs are applied just after a negedge; outputs are compared 1ns later,
    // then the model advances as if the coming posedge has happened.
    task automatic cyc(input logic v, input logic [OP_W-1:0] op, input logic [IDX_W:0] len,
                       input logic st, input logic fl, input logic rs);
        logic ready_exp;
        int   eff;
        I_Valid = v; I_Op = op; I_Len = len; I_Stall = st; I_Flush = fl; reset = rs;
        #1;
        ready_exp = !fl && (sb.size() == 0 || (sb[0].last && !st));
        chk("ready", 32'(O_Ready), 32'(ready_exp));
        chk("valid", 32'(O_Valid), 32'(sb.size() != 0));
        chk("busy",  32'(O_Busy),  32'(sb.size() != 0));
        if (sb.size() != 0) begin
            chk("op",   32'(O_Op),        32'(sb[0].op));
            chk("idx",  32'(O_Slice_Idx), 32'(sb[0].idx));
            chk("last", 32'(O_Last),      32'(sb[0].last));
        end else if (after_clear) begin
            chk("clr_idx",  32'(O_Slice_Idx), 32'd0);
            chk("clr_last", 32'(O_Last),      32'd0);
            if (after_reset) chk("rst_op", 32'(O_Op), 32'd0);
        end
        after_clear = fl || !rs;
        after_reset = !rs;
        if (!rs || fl) begin
            sb.delete();
        end else begin
            if (sb.size() != 0 && !st) begin
                void'(sb.pop_front());
                n_beats++;
            end
            if (v && ready_exp) begin
                eff = (len == 0 || len > NUM_SLICES) ? NUM_SLICES : int'(len);
                for (int i = 0; i < eff; i++) sb.push_back('{op, i, i == eff - 1});
            end
        end
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        reset = 1'b0; I_Valid = 1'b0; I_Op = '0; I_Len = '0; I_Flush = 1'b0; I_Stall = 1'b0;
        @(negedge clock);
        @(negedge clock);
        after_clear = 1'b1;
        after_reset = 1'b1;
        idle(2);

        // single op, len 4
        cyc(1'b1, 16'hA001, 4'd4, 1'b0, 1'b0, 1'b1);
        idle(6);

        // len 8 with a 2-cycle stall on idx 2
        n_beats = 0;
        cyc(1'b1, 16'hB002, 4'd8, 1'b0, 1'b0, 1'b1);
        idle(2);
        cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
        idle(7);
        chk("stall_beats", 32'(n_beats), 32'd8);
        idle(2);

        // back-to-back A (len 2) then B (len 3), valid held
        cyc(1'b1, 16'hC0A0, 4'd2, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 16'hC0B0, 4'd3, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 16'hC0B0, 4'd3, 1'b0, 1'b0, 1'b1);
        idle(5);

        // len 0 and len 12 both become 8 beats
        cyc(1'b1, 16'hD000, 4'd0, 1'b0, 1'b0, 1'b1);
        idle(9);
        cyc(1'b1, 16'hD00C, 4'd12, 1'b0, 1'b0, 1'b1);
        idle(9);

        // len 1: single beat marked last
        cyc(1'b1, 16'hD001, 4'd1, 1'b0, 1'b0, 1'b1);
        idle(3);

        // flush at idx 3 while stalled with a pending op
        cyc(1'b1, 16'hE006, 4'd6, 1'b0, 1'b0, 1'b1);
        idle(3);
        cyc(1'b1, 16'hE0FF, 4'd2, 1'b1, 1'b1, 1'b1);
        cyc(1'b1, 16'hE0FF, 4'd2, 1'b0, 1'b0, 1'b1);
        idle(4);

        // flush in idle only blocks accept that cycle
        cyc(1'b1, 16'hE111, 4'd1, 1'b0, 1'b1, 1'b1);
        idle(2);

        // reset at idx 5 of an 8-beat op, then a fresh op
        cyc(1'b1, 16'hF008, 4'd8, 1'b0, 1'b0, 1'b1);
        idle(5);
        cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        idle(1);
        cyc(1'b1, 16'hF103, 4'd3, 1'b0, 1'b0, 1'b1);
        idle(5);

        // random traffic without flush
        for (int i = 0; i < 200; i++)
            cyc(1'($urandom_range(0, 1)), 16'($urandom), 4'($urandom_range(0, 15)),
                ($urandom_range(0, 3) == 0), 1'b0, 1'b1);
        for (int i = 0; i < 40; i++) cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        chk("drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
